// File: rtl/tdm_mux_8to1.sv
// 8-channel round-robin TDM multiplexer with a single registered output word.
// Optional transfer counter enabled by defining TDM_MUX_STATS_EN.
module tdm_mux_8to1 #(
   parameter int DW = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      in_valid,
   input  logic [8*DW-1:0] in_data,
   output logic [7:0]      in_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [2:0]      out_sel,
   input  logic            out_ready,
   output logic [15:0]     xfer_cnt
);

   logic [2:0]    ptr_q, ptr_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [2:0]    out_sel_q, out_sel_d;
   logic [2:0]    gnt, idx;
   logic          found, load;

   // Search ptr, ptr+1, ... ptr+7; 3-bit add wraps modulo 8 for free.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = ptr_q + 3'(k);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   // rst_n gates load so in_ready stays low throughout reset.
   assign load     = rst_n & (|in_valid) & (~out_valid_q | out_ready);
   assign in_ready = load ? (8'b1 << gnt) : 8'b0;

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[gnt*DW +: DW];
         out_sel_d   = gnt;
         ptr_d       = gnt + 3'd1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

`ifdef TDM_MUX_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_q && out_ready) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign xfer_cnt = cnt_q;
`else
   assign xfer_cnt = 16'd0;
`endif

endmodule

// File: doc/tdm_mux_8to1.md
TDM_MUX_8TO1 -- requirements
Module: tdm_mux_8to1

Interface
REQ-001 SHALL have parameter: DW, 1, data width per channel in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  8  per-channel request; bit i = channel i holds data.
REQ-005 SHALL have port: in_data  input  8*DW  channel i data at bits [i*DW +: DW].
REQ-006 SHALL have port: in_ready  output  8  per-channel accept; at most one bit set per cycle.
REQ-007 SHALL have port: out_valid  output  1  output register holds a word.
REQ-008 SHALL have port: out_data  output  DW  muxed word.
REQ-009 SHALL have port: out_sel  output  3  source channel index of out_data; drives a downstream 1-to-8 demux select.
REQ-010 SHALL have port: out_ready  input  1  downstream accept.
REQ-011 SHALL have port: xfer_cnt  output  16  accepted-output count (see Configuration).

Function
REQ-012 SHALL keep a round-robin pointer ptr[2:0]; ptr marks the highest-priority channel.
REQ-013 SHALL grant the first channel with in_valid set, searching ptr, ptr+1, ... ptr+7, modulo 8.
REQ-014 SHALL define load = (any in_valid) AND (NOT out_valid OR out_ready).
REQ-015 SHALL drive in_ready[g] = load for granted channel g, combinationally; all other in_ready bits 0.
REQ-016 SHALL, on load, register out_data <= channel g data, out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 8.
REQ-017 SHALL have latency of 1 cycle from accepted input to out_valid, with throughput of 1 word/cycle under continuous out_ready.
REQ-018 SHALL clear out_valid when out_valid AND out_ready AND NOT load.
REQ-019 SHALL hold out_data, out_sel, out_valid and ptr stable while out_valid=1 and out_ready=0; in_ready = 0 in that state.
REQ-020 SHALL leave ptr unchanged on cycles without load.
REQ-021 SHALL wrap ptr from 7 to 0 (grant 7 -> ptr 0).
REQ-022 SHALL accept a single requester on every load cycle regardless of ptr (a lone request is never starved).
REQ-023 SHALL, with all 8 requesting continuously, grant in order ptr, ptr+1, ... so that each channel gets exactly 1 of every 8 grants.
REQ-024 SHALL keep out_data/out_sel unchanged when out_valid=0 (no X propagation, last value held).
REQ-025 SHALL NOT let in_ready depend on out_data/out_sel; in_valid is required not to depend on in_ready.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0, ptr=0, xfer_cnt=0, in_ready=0, independent of clk.
REQ-027 SHALL discard any held output word on reset mid-operation; the first grant after release SHALL start at channel 0 priority.
REQ-028 SHALL deassert reset on rst_n rising, with the first load possible on the first clk edge after release.

Configuration
REQ-029 SHALL, with macro TDM_MUX_STATS_EN defined, increment xfer_cnt by 1 on each cycle with out_valid AND out_ready, wrapping 16'hFFFF -> 0.
REQ-030 SHALL, without TDM_MUX_STATS_EN, tie xfer_cnt to 0 and instantiate no counter logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, in_valid=8'h00, out_ready=1 -> out_valid=0, in_ready=0, xfer_cnt=0.
REQ-032 SHALL cover: in_valid=8'hFF held, out_ready=1, DW=1, in_data=8'hA5 -> out_sel 0,1,2,...,7,0 on consecutive cycles, out_data following bits of 8'hA5 = 1,0,1,0,0,1,0,1.
REQ-033 SHALL cover: in_valid=8'b1000_0100, ptr=3 -> grant 7 (out_sel=7), then ptr=0 -> grant 2.
REQ-034 SHALL cover: out_valid=1, out_ready=0 for 5 cycles with in_valid=8'hFF -> out_data/out_sel constant, in_ready=0, ptr unchanged; on out_ready=1, same-cycle load of next channel.
REQ-035 SHALL cover: rst_n pulsed low mid-stream while out_valid=1 -> out_valid=0 immediately (asynchronously), first post-reset grant=channel 0 when in_valid=8'hFF.
REQ-036 SHALL cover: with TDM_MUX_STATS_EN, 65537 accepted outputs -> xfer_cnt=1; without the macro -> xfer_cnt=0.
